inst_loader: RTL and testbench

- Boot-time writer for the 1024 x 16-bit instruction memory: accepts a byte stream on a valid/ready interface and packs byte pairs into 16-bit instruction words.
- Writes each word through a single-port write interface to consecutive addresses starting at a programmed base.
- Holds the CPU in reset via cpu_hold while loading is in progress; releases it when loading completes.

---
 rtl/inst_loader.sv | 91 +++++++++
 tb/tb_inst_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot-time instruction memory loader: packs a byte stream into 16-bit words
// and writes them to consecutive addresses, holding the CPU in reset meanwhile.
module inst_loader #(
   parameter int ADDR_W   = 10,
   parameter bit HI_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              cpu_hold
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BYTE0 = 3'd1;
   localparam logic [2:0] S_BYTE1 = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr_cnt;
   logic [ADDR_W:0]   remaining;
   logic [7:0]        first_byte;
   logic              hs;

   // Stream handshake: a byte moves only when in_valid && in_ready on a rising edge.
   assign in_ready = (state == S_BYTE0) || (state == S_BYTE1);
   assign hs       = in_valid && in_ready;
   assign busy     = in_ready || (state == S_WRITE);
   assign done     = (state == S_FIN);
   assign cpu_hold = busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         addr_cnt   <= '0;
         remaining  <= '0;
         first_byte <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (word_count != '0) begin
                     addr_cnt  <= base_addr;
                     remaining <= word_count;
                     state     <= S_BYTE0;
                  end else begin
                     state <= S_FIN;
                  end
               end
            end
            S_BYTE0: begin
               if (hs) begin
                  first_byte <= in_byte;
                  state      <= S_BYTE1;
               end
            end
            S_BYTE1: begin
               // Address/data are registered here so they hold steady after WRITE.
               if (hs) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_cnt;
                  mem_wdata <= HI_FIRST ? {first_byte, in_byte} : {in_byte, first_byte};
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               addr_cnt  <= addr_cnt + ADDR_W'(1);
               remaining <= remaining - (ADDR_W+1)'(1);
               state     <= (remaining == (ADDR_W+1)'(1)) ? S_FIN : S_BYTE0;
            end
            S_FIN: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: one instance per byte order, fed identical stimulus.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [10:0] word_count = '0;
   logic [7:0]  in_byte = '0;
   logic        in_valid = 1'b0;

   logic        in_ready_h, mem_we_h, busy_h, done_h, cpu_hold_h;
   logic [9:0]  mem_addr_h;
   logic [15:0] mem_wdata_h;
   logic        in_ready_l, mem_we_l, busy_l, done_l, cpu_hold_l;
   logic [9:0]  mem_addr_l;
   logic [15:0] mem_wdata_l;

   int n_pass = 0;
   int n_total = 0;

   logic [7:0]  stream [0:2063];
   int          wr_addr_q[$];
   logic [15:0] wr_h_q[$];
   logic [15:0] wr_l_q[$];
   int          we_cyc_q[$];
   int          hs_cyc_q[$];
   int          done_cnt, hold_err, ready_cnt, hs_cnt, timed_out, done_busy_err;

   always #5 clk = ~clk;

   inst_loader #(.ADDR_W(10), .HI_FIRST(1'b1)) dut_h (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready_h), .mem_we(mem_we_h),
      .mem_addr(mem_addr_h), .mem_wdata(mem_wdata_h), .busy(busy_h), .done(done_h),
      .cpu_hold(cpu_hold_h)
   );

   inst_loader #(.ADDR_W(10), .HI_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready_l), .mem_we(mem_we_l),
      .mem_addr(mem_addr_l), .mem_wdata(mem_wdata_l), .busy(busy_l), .done(done_l),
      .cpu_hold(cpu_hold_l)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one load and records every write, handshake and done pulse.
   task automatic run_load(input logic [9:0] base, input logic [10:0] wc, input bit gapped,
                           input bit noise, input int abort_after, input int budget);
      int  idx;
      int  cyc;
      bit  hs_now;
      bit  done_seen;
      wr_addr_q.delete(); wr_h_q.delete(); wr_l_q.delete();
      we_cyc_q.delete(); hs_cyc_q.delete();
      done_cnt = 0; hold_err = 0; ready_cnt = 0; hs_cnt = 0; timed_out = 0; done_busy_err = 0;
      idx = 0; cyc = 0; done_seen = 1'b0;
      base_addr = base; word_count = wc; start = 1'b1;
      tick();
      start = noise;
      if (noise) begin
         base_addr = 10'd500;
         word_count = 11'd7;
      end
      while (!done_seen && cyc < budget) begin
         in_byte  = stream[idx];
         in_valid = gapped ? ((cyc % 4) == 0) : 1'b1;
         if (cpu_hold_h !== busy_h || cpu_hold_l !== busy_l ||
             {in_ready_h, mem_we_h, busy_h, done_h, mem_addr_h} !==
             {in_ready_l, mem_we_l, busy_l, done_l, mem_addr_l})
            hold_err++;
         if (in_ready_h) ready_cnt++;
         if (mem_we_h === 1'b1) begin
            wr_addr_q.push_back(int'(mem_addr_h));
            wr_h_q.push_back(mem_wdata_h);
            wr_l_q.push_back(mem_wdata_l);
            we_cyc_q.push_back(cyc);
         end
         if (done_h === 1'b1) begin
            done_cnt++;
            if (busy_h !== 1'b0 || cpu_hold_h !== 1'b0) done_busy_err++;
            done_seen = 1'b1;
            start = 1'b0;
         end
         hs_now = (in_ready_h === 1'b1) && in_valid;
         if (hs_now) begin
            hs_cnt++;
            hs_cyc_q.push_back(cyc);
         end
         tick();
         cyc++;
         if (hs_now) idx++;
         if (abort_after != 0 && hs_cnt == abort_after) break;
      end
      start = 1'b0;
      in_valid = 1'b0;
      if (!done_seen && abort_after == 0) timed_out = 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_total++;
      if ({in_ready_h, mem_we_h, mem_addr_h, mem_wdata_h, busy_h, done_h, cpu_hold_h,
           in_ready_l, mem_we_l, mem_addr_l, mem_wdata_l, busy_l, done_l, cpu_hold_l} !== '0)
         $display("FAIL reset_outputs: got nonzero output (we=%b addr=%0d data=%h busy=%b) expected all 0",
                  mem_we_h, mem_addr_h, mem_wdata_h, busy_h);
      else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      stream[0] = 8'hE4; stream[1] = 8'h00; stream[2] = 8'h07; stream[3] = 8'hF4;
      stream[4] = 8'hAA; stream[5] = 8'hBB;
      run_load(10'd0, 11'd2, 1'b0, 1'b0, 0, 40);
      n_total++; if (timed_out != 0) $display("FAIL basic_timeout: got no done expected done"); else n_pass++;
      n_total++; if (wr_addr_q.size() != 2) $display("FAIL basic_nwrites: got %0d expected 2", wr_addr_q.size()); else n_pass++;
      if (wr_addr_q.size() == 2) begin
         n_total++; if (wr_addr_q[0] != 0) $display("FAIL basic_addr0: got %0d expected 0", wr_addr_q[0]); else n_pass++;
         n_total++; if (wr_addr_q[1] != 1) $display("FAIL basic_addr1: got %0d expected 1", wr_addr_q[1]); else n_pass++;
         n_total++; if (wr_h_q[0] !== 16'hE400) $display("FAIL basic_hi_data0: got %h expected e400", wr_h_q[0]); else n_pass++;
         n_total++; if (wr_h_q[1] !== 16'h07F4) $display("FAIL basic_hi_data1: got %h expected 07f4", wr_h_q[1]); else n_pass++;
         n_total++; if (wr_l_q[0] !== 16'h00E4) $display("FAIL basic_lo_data0: got %h expected 00e4", wr_l_q[0]); else n_pass++;
         n_total++; if (wr_l_q[1] !== 16'hF407) $display("FAIL basic_lo_data1: got %h expected f407", wr_l_q[1]); else n_pass++;
      end
      n_total++; if (done_cnt != 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt); else n_pass++;
      n_total++; if (done_busy_err != 0) $display("FAIL basic_busy_in_done: got %0d bad cycles expected 0", done_busy_err); else n_pass++;
      n_total++; if (hold_err != 0) $display("FAIL basic_hold_eq_busy: got %0d bad cycles expected 0", hold_err); else n_pass++;
      n_total++; if (mem_addr_h !== 10'd1 || mem_wdata_h !== 16'h07F4)
         $display("FAIL basic_hold_outputs: got addr=%0d data=%h expected 1/07f4", mem_addr_h, mem_wdata_h);
      else n_pass++;
      n_total++; if (done_h !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", done_h); else n_pass++;
   endtask

   task automatic test_gapped();
      stream[0] = 8'h80; stream[1] = 8'h02; stream[2] = 8'hCC; stream[3] = 8'hDD;
      run_load(10'd9, 11'd1, 1'b1, 1'b0, 0, 60);
      n_total++; if (timed_out != 0) $display("FAIL gap_timeout: got no done expected done"); else n_pass++;
      n_total++; if (wr_h_q.size() != 1) $display("FAIL gap_nwrites: got %0d expected 1", wr_h_q.size()); else n_pass++;
      n_total++; if (hs_cnt != 2) $display("FAIL gap_bytes_consumed: got %0d expected 2", hs_cnt); else n_pass++;
      if (wr_h_q.size() == 1 && hs_cyc_q.size() == 2) begin
         n_total++; if (wr_h_q[0] !== 16'h8002 || wr_addr_q[0] != 9)
            $display("FAIL gap_write: got addr=%0d data=%h expected 9/8002", wr_addr_q[0], wr_h_q[0]);
         else n_pass++;
         n_total++; if (we_cyc_q[0] - hs_cyc_q[1] != 1)
            $display("FAIL gap_latency: got %0d cycles expected 1", we_cyc_q[0] - hs_cyc_q[1]);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 6; i++) stream[i] = 8'(8'h30 + i);
      run_load(10'd1022, 11'd3, 1'b0, 1'b0, 0, 60);
      n_total++; if (wr_addr_q.size() != 3) $display("FAIL wrap_nwrites: got %0d expected 3", wr_addr_q.size()); else n_pass++;
      if (wr_addr_q.size() == 3) begin
         n_total++; if (wr_addr_q[0] != 1022 || wr_addr_q[1] != 1023 || wr_addr_q[2] != 0)
            $display("FAIL wrap_addrs: got %0d,%0d,%0d expected 1022,1023,0", wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]);
         else n_pass++;
         n_total++; if (wr_h_q[2] !== 16'h3435) $display("FAIL wrap_data2: got %h expected 3435", wr_h_q[2]); else n_pass++;
      end
   endtask

   task automatic test_zero_count();
      run_load(10'd77, 11'd0, 1'b0, 1'b0, 0, 4);
      n_total++; if (done_cnt != 1) $display("FAIL zero_done_count: got %0d expected 1", done_cnt); else n_pass++;
      n_total++; if (wr_addr_q.size() != 0) $display("FAIL zero_no_write: got %0d writes expected 0", wr_addr_q.size()); else n_pass++;
      n_total++; if (ready_cnt != 0 || hs_cnt != 0) $display("FAIL zero_in_ready: got %0d ready cycles expected 0", ready_cnt); else n_pass++;
      n_total++; if (done_h !== 1'b0 || busy_h !== 1'b0) $display("FAIL zero_after_done: got done=%b busy=%b expected 0/0", done_h, busy_h); else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) stream[i] = 8'(8'h11 * (i + 1));
      run_load(10'd40, 11'd3, 1'b0, 1'b1, 0, 40);
      n_total++; if (wr_addr_q.size() != 3) $display("FAIL b2b_nwrites: got %0d expected 3", wr_addr_q.size()); else n_pass++;
      if (wr_addr_q.size() == 3) begin
         n_total++; if (wr_addr_q[0] != 40 || wr_addr_q[1] != 41 || wr_addr_q[2] != 42)
            $display("FAIL b2b_start_ignored: got %0d,%0d,%0d expected 40,41,42", wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]);
         else n_pass++;
         n_total++; if (we_cyc_q[1] - we_cyc_q[0] != 3 || we_cyc_q[2] - we_cyc_q[1] != 3)
            $display("FAIL b2b_throughput: got spacing %0d,%0d expected 3,3", we_cyc_q[1] - we_cyc_q[0], we_cyc_q[2] - we_cyc_q[1]);
         else n_pass++;
         n_total++; if (wr_h_q[2] !== 16'h5566 || wr_l_q[2] !== 16'h6655)
            $display("FAIL b2b_data2: got %h/%h expected 5566/6655", wr_h_q[2], wr_l_q[2]);
         else n_pass++;
      end
      n_total++; if (done_cnt != 1) $display("FAIL b2b_done_count: got %0d expected 1", done_cnt); else n_pass++;
   endtask

   task automatic test_full_memory();
      int last_exp;
      for (int i = 0; i < 2064; i++) stream[i] = 8'(i) ^ 8'h5A;
      run_load(10'd5, 11'd1024, 1'b0, 1'b0, 0, 3200);
      n_total++; if (wr_addr_q.size() != 1024) $display("FAIL full_nwrites: got %0d expected 1024", wr_addr_q.size()); else n_pass++;
      n_total++; if (hs_cnt != 2048) $display("FAIL full_bytes: got %0d expected 2048", hs_cnt); else n_pass++;
      if (wr_addr_q.size() == 1024) begin
         last_exp = 4;
         n_total++; if (wr_addr_q[0] != 5 || wr_addr_q[1023] != last_exp)
            $display("FAIL full_addr_range: got %0d..%0d expected 5..4", wr_addr_q[0], wr_addr_q[1023]);
         else n_pass++;
         n_total++; if (wr_h_q[1023] !== {stream[2046], stream[2047]})
            $display("FAIL full_last_data: got %h expected %h", wr_h_q[1023], {stream[2046], stream[2047]});
         else n_pass++;
      end
      n_total++; if (done_cnt != 1) $display("FAIL full_done_count: got %0d expected 1", done_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_load();
      int late_we;
      for (int i = 0; i < 8; i++) stream[i] = 8'(8'hA0 + i);
      run_load(10'd200, 11'd4, 1'b0, 1'b0, 3, 40);
      n_total++; if (wr_addr_q.size() != 1) $display("FAIL abort_writes_before: got %0d expected 1", wr_addr_q.size()); else n_pass++;
      in_valid = 1'b1;
      rst = 1'b1;
      late_we = (mem_we_h === 1'b1) ? 1 : 0;
      tick();
      n_total++; if ({in_ready_h, mem_we_h, mem_addr_h, mem_wdata_h, busy_h, done_h, cpu_hold_h} !== '0)
         $display("FAIL abort_outputs_zero: got we=%b addr=%0d busy=%b expected all 0", mem_we_h, mem_addr_h, busy_h);
      else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (mem_we_h === 1'b1 || busy_h === 1'b1) late_we++;
         tick();
      end
      in_valid = 1'b0;
      n_total++; if (late_we != 0) $display("FAIL abort_no_more_writes: got %0d active cycles expected 0", late_we); else n_pass++;
      stream[0] = 8'h12; stream[1] = 8'h34;
      run_load(10'd300, 11'd1, 1'b0, 1'b0, 0, 40);
      n_total++; if (wr_addr_q.size() != 1) $display("FAIL reload_nwrites: got %0d expected 1", wr_addr_q.size()); else n_pass++;
      if (wr_addr_q.size() == 1) begin
         n_total++; if (wr_addr_q[0] != 300 || wr_h_q[0] !== 16'h1234 || wr_l_q[0] !== 16'h3412)
            $display("FAIL reload_write: got addr=%0d data=%h/%h expected 300 1234/3412", wr_addr_q[0], wr_h_q[0], wr_l_q[0]);
         else n_pass++;
      end
   endtask

   initial begin
      for (int i = 0; i < 2064; i++) stream[i] = 8'h00;
      test_reset();
      test_basic();
      test_gapped();
      test_wrap();
      test_zero_count();
      test_back_to_back();
      test_full_memory();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
